// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
package mult_sched_pkg;

  localparam int unsigned OP_W             = 32;
  localparam int unsigned PROD_W           = 64;
  localparam int unsigned DRAIN_CYCLES_DEF = 40;

  typedef enum logic [4:0] {
    S_DRAIN = 5'b00001,
    S_IDLE  = 5'b00010,
    S_ISSUE = 5'b00100,
    S_WAIT  = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after last_grant.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic w_found;

  // Two passes: indices above the pointer first, then wrap to the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && req[i] && (i > int'(last_grant))) begin
        w_found   = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && req[i] && (i <= int'(last_grant))) begin
        w_found   = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative multiplier among NREQ requesters.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OP_W*NREQ-1:0] req_op1,
  input  logic [OP_W*NREQ-1:0] req_op2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [PROD_W-1:0]    resp_product,
  output logic                 busy,
  output logic                 mult_begin,
  output logic [OP_W-1:0]      mult_op1,
  output logic [OP_W-1:0]      mult_op2,
  input  logic [PROD_W-1:0]    product,
  input  logic                 mult_end
);

  localparam int unsigned IDX_W = idx_width(NREQ);
  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_id;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [NREQ-1:0]     w_grant;
  logic [OP_W-1:0]     r_op1;
  logic [OP_W-1:0]     r_op2;
  logic [OP_W-1:0]     w_sel_op1;
  logic [OP_W-1:0]     w_sel_op2;
  logic [PROD_W-1:0]   r_product;
  logic [NREQ-1:0]     r_resp_valid;
  logic                r_busy;
  logic                r_mult_begin;
  logic                w_accept;
  logic                w_resp_take;
  logic                w_drain_done;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (r_ptr),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  assign req_ready    = (r_state == S_IDLE) ? w_grant : '0;
  assign w_accept     = |(req_valid & req_ready);
  assign w_resp_take  = resp_ready[r_id];
  assign w_drain_done = (r_cnt == CNT_W'(DRAIN_CYCLES - 1));

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_op1 = '0;
    w_sel_op2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_sel_op1 = req_op1[i*OP_W +: OP_W];
        w_sel_op2 = req_op2[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_DRAIN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_accept)     w_state_nxt = S_ISSUE;
      S_ISSUE:                   w_state_nxt = S_WAIT;
      S_WAIT:  if (mult_end)     w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_take)  w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_DRAIN;
    endcase
  end

  // Datapath and registered outputs, derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_ptr        <= IDX_W'(NREQ - 1);
      r_id         <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_product    <= '0;
      r_resp_valid <= '0;
      r_busy       <= 1'b1;
      r_mult_begin <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_DRAIN) ? r_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_op1 <= w_sel_op1;
        r_op2 <= w_sel_op2;
        r_id  <= w_grant_idx;
        r_ptr <= w_grant_idx;
      end
      if ((r_state == S_WAIT) && mult_end) r_product <= product;
      r_mult_begin <= (w_state_nxt == S_ISSUE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP) ? (NREQ'(1) << r_id) : '0;
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_product = r_product;
  assign busy         = r_busy;
  assign mult_begin   = r_mult_begin;
  assign mult_op1     = r_op1;
  assign mult_op2     = r_op2;

endmodule
